// File: rtl/udma_rx_ch_arbiter_if.sv
// Lane-side and core-side signal bundle for udma_rx_ch_arbiter.
// slave = arbiter view, master = the surrounding peripheral/core view.
interface udma_rx_ch_arbiter_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int DEST_W = 8
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]        clr_i;
  logic [N_CH-1:0]        in_valid_i;
  logic [N_CH*DATA_W-1:0] in_data_i;
  logic [N_CH*2-1:0]      in_datasize_i;
  logic [N_CH*DEST_W-1:0] in_dest_i;
  logic [N_CH-1:0]        in_ready_o;
  logic                   out_valid_o;
  logic [DATA_W-1:0]      out_data_o;
  logic [1:0]             out_datasize_o;
  logic [DEST_W-1:0]      out_dest_o;
  logic [CH_W-1:0]        out_ch_o;
  logic                   out_ready_i;
  logic [N_CH-1:0]        lane_pending_o;

  modport slave (
    input  clr_i, in_valid_i, in_data_i, in_datasize_i, in_dest_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_datasize_o, out_dest_o,
           out_ch_o, lane_pending_o
  );

  modport master (
    output clr_i, in_valid_i, in_data_i, in_datasize_i, in_dest_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_datasize_o, out_dest_o,
           out_ch_o, lane_pending_o
  );
endinterface

// File: rtl/udma_rx_ch_arbiter.sv
// N-lane RX stream merger: per-lane FIFOs, round-robin arbiter, registered output stage.
// Optional burst locking of the granted lane with `define UDMA_RX_ARB_BURST_LOCK_EN.
module udma_rx_ch_arbiter #(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 32,
  parameter int DEST_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  udma_rx_ch_arbiter_if.slave     bus
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + 2 + DEST_W;

  if (N_CH < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BURST_LEN < 1)
  begin : g_param_check
    $error("udma_rx_ch_arbiter: invalid parameter set");
  end

  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  in_ready_vec;
  logic [N_CH-1:0]  req;
  logic [ENT_W-1:0] head [N_CH];
  logic [CH_W-1:0]  rr_ptr_reg;
  logic [CH_W-1:0]  rr_idx;
  logic             rr_found;
  logic [CH_W-1:0]  grant_idx;
  logic             grant_found;
  logic             load_en;
  logic             pop_en;

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [1:0]        out_datasize_reg;
  logic [DEST_W-1:0] out_dest_reg;
  logic [CH_W-1:0]   out_ch_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic             push;
    logic             pop;

    // Readiness comes from the registered count only, so a full lane never
    // accepts even when it is being drained in the same cycle.
    assign in_ready_vec[gi] = (count_reg != CNT_W'(FIFO_DEPTH));
    assign pending[gi]      = (count_reg != '0);
    assign push             = bus.in_valid_i[gi] & in_ready_vec[gi] & ~bus.clr_i[gi];
    assign pop              = pop_en & (grant_idx == CH_W'(gi));
    assign head[gi]         = mem[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
      if (push) begin
        mem[wr_ptr_reg] <= {bus.in_data_i[gi*DATA_W +: DATA_W],
                            bus.in_datasize_i[gi*2 +: 2],
                            bus.in_dest_i[gi*DEST_W +: DEST_W]};
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else if (bus.clr_i[gi]) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push && !pop)      count_reg <= count_reg + 1'b1;
        else if (pop && !push) count_reg <= count_reg - 1'b1;
      end
    end
  end

  // A lane being flushed this cycle is not eligible for a grant.
  assign req = pending & ~bus.clr_i;

  always_comb begin
    logic [CH_W-1:0] idx;
    rr_found = 1'b0;
    rr_idx   = '0;
    idx      = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = CH_W'((int'(rr_ptr_reg) + i) % N_CH);
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_idx   = idx;
      end
    end
  end

`ifdef UDMA_RX_ARB_BURST_LOCK_EN
  localparam int BURST_W = $clog2(BURST_LEN) + 1;
  logic [BURST_W-1:0] burst_cnt_reg;
  logic [BURST_W-1:0] burst_cnt_next;
  logic               lock_hold;

  // rr_ptr_reg always names the most recently granted lane, i.e. the lock owner.
  assign lock_hold   = (burst_cnt_reg != '0) && (burst_cnt_reg < BURST_W'(BURST_LEN))
                       && req[rr_ptr_reg];
  assign grant_found = lock_hold | rr_found;
  assign grant_idx   = lock_hold ? rr_ptr_reg : rr_idx;

  always_comb begin
    burst_cnt_next = burst_cnt_reg;
    if (pop_en) begin
      burst_cnt_next = lock_hold ? burst_cnt_reg + 1'b1 : BURST_W'(1);
    end else if (!req[rr_ptr_reg]) begin
      burst_cnt_next = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) burst_cnt_reg <= '0;
    else         burst_cnt_reg <= burst_cnt_next;
  end
`else
  assign grant_found = rr_found;
  assign grant_idx   = rr_idx;
`endif

  assign load_en = !out_valid_reg | bus.out_ready_i;
  assign pop_en  = load_en & grant_found;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr_reg       <= CH_W'(N_CH - 1);
      out_valid_reg    <= 1'b0;
      out_data_reg     <= '0;
      out_datasize_reg <= '0;
      out_dest_reg     <= '0;
      out_ch_reg       <= '0;
    end else if (load_en) begin
      out_valid_reg <= grant_found;
      if (grant_found) begin
        {out_data_reg, out_datasize_reg, out_dest_reg} <= head[grant_idx];
        out_ch_reg <= grant_idx;
        rr_ptr_reg <= grant_idx;
      end
    end
  end

  assign bus.in_ready_o     = in_ready_vec;
  assign bus.lane_pending_o = pending;
  assign bus.out_valid_o    = out_valid_reg;
  assign bus.out_data_o     = out_data_reg;
  assign bus.out_datasize_o = out_datasize_reg;
  assign bus.out_dest_o     = out_dest_reg;
  assign bus.out_ch_o       = out_ch_reg;
endmodule

// File: tb/tb_udma_rx_ch_arbiter.sv
// Directed and randomized self-checking bench for udma_rx_ch_arbiter.
module tb_udma_rx_ch_arbiter;
  localparam int N_CH       = 4;
  localparam int DATA_W     = 32;
  localparam int DEST_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int BURST_LEN  = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  udma_rx_ch_arbiter_if #(.N_CH(N_CH), .DATA_W(DATA_W), .DEST_W(DEST_W)) bif ();

  udma_rx_ch_arbiter #(
    .N_CH(N_CH), .DATA_W(DATA_W), .DEST_W(DEST_W),
    .FIFO_DEPTH(FIFO_DEPTH), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bif.slave)
  );

  task automatic drive_idle();
    bif.clr_i         = '0;
    bif.in_valid_i    = '0;
    bif.in_data_i     = '0;
    bif.in_datasize_i = '0;
    bif.in_dest_i     = '0;
    bif.out_ready_i   = 1'b0;
  endtask

  task automatic set_lane(input int k, input logic [31:0] d, input logic [7:0] dest,
                          input logic [1:0] sz);
    bif.in_data_i[k*DATA_W +: DATA_W]     = d;
    bif.in_dest_i[k*DEST_W +: DEST_W]     = dest;
    bif.in_datasize_i[k*2 +: 2]           = sz;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b1;
    bif.out_ready_i = 1'b0;
    bif.clr_i = '0;
    bif.in_valid_i = 4'b0001;
    set_lane(0, 32'h1111_1111, 8'h01, 2'b10);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    total++;
    if (bif.out_valid_o !== 1'b0 || bif.lane_pending_o !== 4'b0000 || bif.in_ready_o !== 4'b1111) begin
      bad++;
      $display("FAIL reset_async: valid=%b pending=%b ready=%b required 0/0000/1111",
               bif.out_valid_o, bif.lane_pending_o, bif.in_ready_o);
    end
    drive_idle();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (bif.out_valid_o !== 1'b0 || bif.lane_pending_o !== 4'b0000 || bif.in_ready_o !== 4'b1111 ||
        bif.out_data_o !== 32'h0 || bif.out_ch_o !== 2'd0 || bif.out_dest_o !== 8'h0) begin
      bad++;
      $display("FAIL reset_release: valid=%b pending=%b ready=%b data=%h ch=%0d required 0/0000/1111/0/0",
               bif.out_valid_o, bif.lane_pending_o, bif.in_ready_o, bif.out_data_o, bif.out_ch_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_lane();
    apply_reset();
    bif.out_ready_i = 1'b1;
    set_lane(2, 32'hA5A5_0002, 8'h12, 2'b10);
    bif.in_valid_i = 4'b0100;
    @(negedge clk);
    bif.in_valid_i = '0;
    total++;
    if (bif.out_valid_o !== 1'b0 || bif.lane_pending_o !== 4'b0100) begin
      bad++;
      $display("FAIL single_latency: valid=%b pending=%b required 0/0100",
               bif.out_valid_o, bif.lane_pending_o);
    end
    @(negedge clk);
    total++;
    if (bif.out_valid_o !== 1'b1 || bif.out_data_o !== 32'hA5A5_0002 || bif.out_dest_o !== 8'h12 ||
        bif.out_ch_o !== 2'd2 || bif.out_datasize_o !== 2'b10) begin
      bad++;
      $display("FAIL single_beat: valid=%b data=%h dest=%h ch=%0d size=%b required 1/a5a50002/12/2/10",
               bif.out_valid_o, bif.out_data_o, bif.out_dest_o, bif.out_ch_o, bif.out_datasize_o);
    end
    @(negedge clk);
    total++;
    if (bif.out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL single_drain: valid=%b required 0", bif.out_valid_o);
    end
    $display("test_single_lane done");
  endtask

  task automatic test_round_robin();
    int exp_ch [12];
    int lane_seen [N_CH];
    int got_ch [12];
    logic [31:0] got_data [12];
    int n;
    int cyc;
`ifdef UDMA_RX_ARB_BURST_LOCK_EN
    exp_ch = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
`else
    exp_ch = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
`endif
    apply_reset();
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < N_CH; k++) set_lane(k, {8'(k), 8'h00, 16'(j)}, 8'(8'h40 + k), 2'b10);
      bif.in_valid_i = 4'b1111;
      @(negedge clk);
    end
    bif.in_valid_i = '0;
    total++;
    if (bif.lane_pending_o !== 4'b1111 || bif.out_valid_o !== 1'b1 || bif.out_ch_o !== 2'd0) begin
      bad++;
      $display("FAIL rr_fill: pending=%b valid=%b ch=%0d required 1111/1/0",
               bif.lane_pending_o, bif.out_valid_o, bif.out_ch_o);
    end
    bif.out_ready_i = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 12 && cyc < 40) begin
      if (bif.out_valid_o) begin
        got_ch[n] = int'(bif.out_ch_o);
        got_data[n] = bif.out_data_o;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (n != 12) begin
      bad++;
      $display("FAIL rr_timeout: beats=%0d required 12", n);
    end
    for (int k = 0; k < N_CH; k++) lane_seen[k] = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] exp_d;
      exp_d = {8'(exp_ch[i]), 8'h00, 16'(lane_seen[exp_ch[i]])};
      lane_seen[exp_ch[i]]++;
      total++;
      if (got_ch[i] != exp_ch[i] || got_data[i] !== exp_d) begin
        bad++;
        $display("FAIL rr_order[%0d]: ch=%0d data=%h required ch=%0d data=%h",
                 i, got_ch[i], got_data[i], exp_ch[i], exp_d);
      end
    end
    total++;
    if (bif.out_valid_o !== 1'b0 || bif.lane_pending_o !== 4'b0000) begin
      bad++;
      $display("FAIL rr_empty: valid=%b pending=%b required 0/0000",
               bif.out_valid_o, bif.lane_pending_o);
    end
    $display("test_round_robin done");
  endtask

  task automatic test_full_hold();
    int acc;
    apply_reset();
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      set_lane(1, 32'hB000_0000 + acc, 8'h21, 2'b01);
      bif.in_valid_i = 4'b0010;
      if (bif.in_ready_o[1]) acc++;
      @(negedge clk);
    end
    bif.in_valid_i = '0;
    total++;
    if (acc != 5 || bif.in_ready_o[1] !== 1'b0) begin
      bad++;
      $display("FAIL full_accept: accepted=%0d ready1=%b required 5/0", acc, bif.in_ready_o[1]);
    end
    for (int c = 0; c < 10; c++) begin
      total++;
      if (bif.out_valid_o !== 1'b1 || bif.out_data_o !== 32'hB000_0000 || bif.out_ch_o !== 2'd1 ||
          bif.out_dest_o !== 8'h21 || bif.out_datasize_o !== 2'b01 || bif.in_ready_o[1] !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable[%0d]: valid=%b data=%h ch=%0d ready1=%b required 1/b0000000/1/0",
                 c, bif.out_valid_o, bif.out_data_o, bif.out_ch_o, bif.in_ready_o[1]);
      end
      @(negedge clk);
    end
    // Push offered to a full lane while it is popped must still be refused.
    set_lane(1, 32'hB000_0099, 8'h21, 2'b01);
    bif.in_valid_i = 4'b0010;
    bif.out_ready_i = 1'b1;
    @(negedge clk);
    bif.in_valid_i = '0;
    total++;
    if (bif.in_ready_o[1] !== 1'b1 || bif.out_data_o !== 32'hB000_0001) begin
      bad++;
      $display("FAIL full_pop: ready1=%b data=%h required 1/b0000001", bif.in_ready_o[1], bif.out_data_o);
    end
    for (int i = 1; i < 5; i++) begin
      total++;
      if (bif.out_valid_o !== 1'b1 || bif.out_data_o !== 32'hB000_0000 + i) begin
        bad++;
        $display("FAIL full_drain[%0d]: valid=%b data=%h required 1/%h",
                 i, bif.out_valid_o, bif.out_data_o, 32'hB000_0000 + i);
      end
      @(negedge clk);
    end
    total++;
    if (bif.out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL full_extra: valid=%b data=%h required no further beat", bif.out_valid_o, bif.out_data_o);
    end
    $display("test_full_hold done");
  endtask

  task automatic test_clear();
    apply_reset();
    for (int j = 0; j < 3; j++) begin
      set_lane(3, 32'hC300_0000 + j, 8'h33, 2'b00);
      bif.in_valid_i = 4'b1000;
      @(negedge clk);
    end
    bif.in_valid_i = '0;
    total++;
    if (bif.lane_pending_o !== 4'b1000 || bif.out_valid_o !== 1'b1 || bif.out_data_o !== 32'hC300_0000) begin
      bad++;
      $display("FAIL clr_setup: pending=%b valid=%b data=%h required 1000/1/c3000000",
               bif.lane_pending_o, bif.out_valid_o, bif.out_data_o);
    end
    bif.clr_i = 4'b1000;
    set_lane(0, 32'h0000_000A, 8'h0A, 2'b01);
    bif.in_valid_i = 4'b0001;
    @(negedge clk);
    bif.clr_i = '0;
    bif.in_valid_i = '0;
    total++;
    if (bif.lane_pending_o !== 4'b0001 || bif.in_ready_o[3] !== 1'b1 || bif.out_valid_o !== 1'b1 ||
        bif.out_data_o !== 32'hC300_0000 || bif.out_ch_o !== 2'd3) begin
      bad++;
      $display("FAIL clr_flush: pending=%b ready3=%b valid=%b data=%h ch=%0d required 0001/1/1/c3000000/3",
               bif.lane_pending_o, bif.in_ready_o[3], bif.out_valid_o, bif.out_data_o, bif.out_ch_o);
    end
    bif.out_ready_i = 1'b1;
    @(negedge clk);
    total++;
    if (bif.out_valid_o !== 1'b1 || bif.out_data_o !== 32'h0000_000A || bif.out_ch_o !== 2'd0) begin
      bad++;
      $display("FAIL clr_other_lane: valid=%b data=%h ch=%0d required 1/0000000a/0",
               bif.out_valid_o, bif.out_data_o, bif.out_ch_o);
    end
    @(negedge clk);
    total++;
    if (bif.out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL clr_dropped: valid=%b data=%h required 0", bif.out_valid_o, bif.out_data_o);
    end
    $display("test_clear done");
  endtask

  task automatic test_random();
    int pushed [N_CH];
    int popped [N_CH];
    int wait_cnt [N_CH];
    int max_wait;
    int prints;
    int cyc;
    logic ready;
    apply_reset();
    for (int k = 0; k < N_CH; k++) begin
      pushed[k] = 0;
      popped[k] = 0;
      wait_cnt[k] = 0;
    end
    max_wait = 0;
    prints = 0;
    cyc = 0;
    while (cyc < 10200) begin
      if (cyc < 10000) ready = ($urandom_range(0, 3) != 0);
      else             ready = 1'b1;
      bif.out_ready_i = ready;
      if (bif.out_valid_o && ready) begin
        int c;
        logic [31:0] exp_d;
        c = int'(bif.out_ch_o);
        exp_d = {8'(c), 8'h00, 16'(popped[c])};
        total++;
        if (bif.out_data_o !== exp_d || bif.out_dest_o !== 8'(8'h40 + c) ||
            bif.out_datasize_o !== 2'(c % 3)) begin
          bad++;
          if (prints < 10) begin
            prints++;
            $display("FAIL rand_beat: ch=%0d data=%h dest=%h size=%b required data=%h dest=%h",
                     c, bif.out_data_o, bif.out_dest_o, bif.out_datasize_o, exp_d, 8'(8'h40 + c));
          end
        end
        popped[c]++;
        for (int k = 0; k < N_CH; k++) begin
          if (k == c || !bif.lane_pending_o[k]) wait_cnt[k] = 0;
          else wait_cnt[k]++;
          if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
        end
      end
      for (int k = 0; k < N_CH; k++) begin
        logic v;
        v = (cyc < 10000) && ($urandom_range(0, 1) == 1);
        if (v) set_lane(k, {8'(k), 8'h00, 16'(pushed[k])}, 8'(8'h40 + k), 2'(k % 3));
        bif.in_valid_i[k] = v;
        if (v && bif.in_ready_o[k]) pushed[k]++;
      end
      @(negedge clk);
      cyc++;
      if (cyc >= 10000 && !bif.out_valid_o && bif.lane_pending_o == '0) break;
    end
    bif.in_valid_i = '0;
    total++;
    if (bif.out_valid_o !== 1'b0 || bif.lane_pending_o !== 4'b0000) begin
      bad++;
      $display("FAIL rand_drain_timeout: valid=%b pending=%b required 0/0000",
               bif.out_valid_o, bif.lane_pending_o);
    end
    for (int k = 0; k < N_CH; k++) begin
      total++;
      if (pushed[k] != popped[k] || pushed[k] == 0) begin
        bad++;
        $display("FAIL rand_count[%0d]: popped=%0d required pushed=%0d (nonzero)", k, popped[k], pushed[k]);
      end
    end
    total++;
    if (max_wait > N_CH * BURST_LEN) begin
      bad++;
      $display("FAIL rand_starve: max_wait=%0d required <= %0d", max_wait, N_CH * BURST_LEN);
    end
    $display("test_random done: beats=%0d/%0d/%0d/%0d max_wait=%0d",
             popped[0], popped[1], popped[2], popped[3], max_wait);
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single_lane();
    test_round_robin();
    test_full_hold();
    test_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/udma_rx_ch_arbiter.md
Name: udma_rx_ch_arbiter

Overview:
- Parametrised N-lane merger of peripheral RX streams (valid/data/datasize/destination) onto one uDMA core RX channel.
- Each lane has its own small FIFO; lanes are served by a round-robin arbiter into a registered output stage.
- Used where one peripheral exposes several RX sub-streams but the core has one RX slot; out_ch_o identifies the source lane.

Parameters:
- N_CH, 4, number of input lanes (>=2)
- DATA_W, 32, data width per beat
- DEST_W, 8, destination field width
- FIFO_DEPTH, 4, entries per lane FIFO (power of 2, >=2)
- BURST_LEN, 4, max consecutive beats per grant (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- clr_i  in  N_CH  per-lane synchronous flush
- in_valid_i  in  N_CH  lane beat valid
- in_data_i  in  N_CH*DATA_W  lane data, lane k at [k*DATA_W +: DATA_W]
- in_datasize_i  in  N_CH*2  00 byte, 01 half, 10 word
- in_dest_i  in  N_CH*DEST_W  lane destination
- in_ready_o  out  N_CH  lane FIFO not full
- out_valid_o  out  1  output beat valid
- out_data_o  out  DATA_W  output data
- out_datasize_o  out  2  output datasize
- out_dest_o  out  DEST_W  output destination
- out_ch_o  out  $clog2(N_CH)  source lane of output beat
- out_ready_i  in  1  core accepts beat
- lane_pending_o  out  N_CH  lane FIFO non-empty

Behaviour:
- Reset (rstn_i low, async): FIFOs empty, pointers 0, out_valid_o/out_data_o/out_datasize_o/out_dest_o/out_ch_o = 0, lane_pending_o = 0, in_ready_o = all ones, RR pointer = N_CH-1 (lane 0 has first priority).
- Lane FIFO: push on in_valid_i[k] & in_ready_o[k]; in_ready_o[k] = (count_k != FIFO_DEPTH), taken from registered count only; no combinational path from out_ready_i. A full FIFO refuses a push even when it is popped in the same cycle. Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; count is $clog2(FIFO_DEPTH)+1 bits.
- Output stage: load enabled when !out_valid_o | out_ready_i. When enabled and any lane is pending, pop the granted lane and register {data, datasize, dest, lane}, out_valid_o = 1. When enabled and no lane is pending, out_valid_o = 0. Back-to-back throughput: 1 beat/cycle.
- Latency: a beat pushed into an empty FIFO at edge t is popped at edge t+1, so out_valid_o is high in the cycle after t+1. No bypass path.
- Hold: while out_valid_o & !out_ready_i, all out_* remain stable and no pop occurs.
- Arbitration: grant the first pending lane searching from RR pointer+1 with modulo-N_CH wrap. The RR pointer updates to the granted lane only on a pop.
- clr_i[k]: at the next edge, FIFO k is emptied (pointers and count zeroed) and any push or pop on lane k in that cycle is discarded. Other lanes are unaffected. A lane-k beat already in the output register is still delivered.
- Simultaneous push and pop on a non-full, non-empty lane: count is unchanged and both take effect.
- out_datasize_o and data are forwarded unmodified; no packing.

Optional Feature:
- Macro UDMA_RX_ARB_BURST_LOCK_EN.
- Defined: after a grant, the arbiter keeps the same lane for up to BURST_LEN consecutive pops while that lane stays pending. A beat counter ($clog2(BURST_LEN)+1 bits) resets on a lane switch or when the lane goes empty. The lock is released early by clr_i of the locked lane.
- Undefined: pure round-robin, one beat per grant; BURST_LEN is ignored and the counter is not instantiated.

Test Plan:
- Reset check: release rstn_i -> in_ready_o = 4'b1111, out_valid_o = 0, lane_pending_o = 0.
- Single lane 2 pushes 0xA5A5_0002 with dest 8'h12 at edge t, out_ready_i = 1 -> out_valid_o high after edge t+1 with data 0xA5A5_0002, dest 8'h12, out_ch_o = 2.
- All 4 lanes hold 3 beats each, out_ready_i = 1 -> out_ch_o sequence 0,1,2,3,0,1,2,3,0,1,2,3 (feature off); with burst lock, BURST_LEN = 2 -> 0,0,1,1,2,2,3,3,0,1,2,3.
- Lane 1 filled with 4 beats and out_ready_i = 0 -> in_ready_o[1] = 0, out_* stable for 10 cycles, and no further push is accepted while lane 1 is full.
- Lane 3 holds 3 beats, one of them in the output register, then clr_i[3] pulses -> the registered beat is delivered, the other 2 are dropped, and lane_pending_o[3] = 0 the cycle after.
- Random in_valid_i/out_ready_i for 10k cycles -> scoreboard shows per-lane order preserved, no loss or duplication, and no lane starved for more than N_CH*BURST_LEN grants.
